dac_spi_out: RTL
================

Name: dac_spi_out

Overview:
- Downstream consumer of the eight-channel summed sample stream (signed 16-bit `results` plus `activeout` flag).
- Decimates the stream to a fixed DAC update rate and serialises each kept sample as a 16-bit SPI frame to an external single-channel DAC.
- Sits between the summing tree and the board DAC pins; reports overrun when the frame rate cannot keep up.

Parameters:
- SCLK_DIV, 2, clk cycles per SCLK half-period; legal values ≥1.
- SAMPLE_DIV, 100, clk cycles per DAC update tick; legal values ≥2; must be ≥ 35*SCLK_DIV+1 for overrun-free operation.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset.
- sample  input  16  signed sample from the summing stage.
- activein  input  1  sample qualifier, from the summing stage's activeout.
- clear_overrun  input  1  synchronous clear of the sticky overrun flag.
- sclk  output  1  SPI clock; idles low; DAC samples on the rising edge.
- mosi  output  1  SPI data, MSB first; changes only while sclk is low.
- cs_n  output  1  DAC chip select, active-low.
- busy  output  1  high whenever state ≠ IDLE.
- frame_done  output  1  one-cycle pulse on the GAP→IDLE transition.
- overrun  output  1  sticky flag: an update tick arrived while not IDLE.

Behaviour:
- Reset values (async assert, all registered outputs): cs_n=1, sclk=0, mosi=0, busy=0, frame_done=0, overrun=0, tick counter=0, state=IDLE.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1, then wraps to 0.
  - tick is true in the cycle where count==SAMPLE_DIV-1.
  - First tick occurs at cycle SAMPLE_DIV after reset release.
- Tick handling:
  - Tick & IDLE & activein: load shift register with conv(sample); go to LEAD.
  - Tick & IDLE & !activein: no frame; the DAC holds its last value.
  - Tick & !IDLE: set overrun; the sample is dropped; the frame in progress is unaffected.
- conv(): see Optional Feature.
- FSM: IDLE → LEAD → SHIFT → TRAIL → GAP → IDLE.
  - LEAD: SCLK_DIV cycles; cs_n=0, sclk=0, mosi=bit15.
  - SHIFT: 16 bits, each bit is SCLK_DIV cycles with sclk=0 followed by SCLK_DIV cycles with sclk=1. mosi is updated to the next bit at the start of each low phase.
  - TRAIL: SCLK_DIV cycles; sclk=0, cs_n=0.
  - GAP: SCLK_DIV cycles; cs_n=1, mosi=0. frame_done=1 in the final GAP cycle; IDLE is entered on the next cycle.
- Timing, for a tick at cycle T:
  - cs_n falls at T+1.
  - First sclk rise at T+1+2*SCLK_DIV.
  - cs_n rises at T+1+34*SCLK_DIV.
  - Total frame = 35*SCLK_DIV cycles.
- All pin outputs come directly from flops, with no combinational paths to pins.
- clear_overrun and an overrun event in the same cycle: set wins, so overrun=1.
- Reset asserted mid-frame: the frame aborts immediately; cs_n=1 and sclk=0 asynchronously. After release the block restarts at IDLE with count=0.
- sample and activein are sampled only on tick cycles; values between ticks are ignored.

Optional Feature:
- Macro: DAC_OFFSET_BINARY_EN.
- Defined: conv(x) = {~x[15], x[14:0]}, i.e. two's complement to offset binary. Example: 16'h8000 → 16'h0000, 16'h0000 → 16'h8000.
- Undefined: conv(x) = x, transmitted unchanged as two's complement.

Test Plan:
- SCLK_DIV=2, SAMPLE_DIV=100, feature on, sample=16'h1234, activein=1 → one frame; bits captured on sclk rises = 16'h9234; cs_n low for 68 cycles starting 1 cycle after tick; frame_done pulses once; overrun=0.
- Same configuration, feature off, sample=16'h8000 → captured 16'h8000; with feature on, sample=16'h7FFF → captured 16'hFFFF.
- activein=0 at the tick → cs_n stays 1, busy stays 0, no sclk edges.
- SAMPLE_DIV=40, SCLK_DIV=2 (frame = 70 cycles) → the second tick lands mid-frame: overrun=1, first frame completes intact. Then assert clear_overrun in the same cycle as the next overrun → overrun stays 1.
- Reset driven low at the 5th sclk rise → cs_n=1 and sclk=0 within the same cycle. After release: next frame starts on tick SAMPLE_DIV cycles later and transmits the new sample correctly.
- SCLK_DIV=1, SAMPLE_DIV=36 → back-to-back frames with no overrun; exactly 16 sclk rises per cs_n-low window.

Source files
------------

// File: rtl/dac_spi_out.sv
// Decimates the summed sample stream to a fixed update rate and shifts each kept sample to a 16-bit SPI DAC.
// Optional DAC_OFFSET_BINARY_EN: transmit offset binary instead of two's complement.
module dac_spi_out #(
  parameter int SCLK_DIV   = 2,
  parameter int SAMPLE_DIV = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample,
  input  logic        activein,
  input  logic        clear_overrun,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  // state | meaning
  // IDLE  | waiting for an update tick
  // LEAD  | cs_n low, MSB presented, sclk low
  // SHIFT | 16 bits, low phase then high phase each
  // TRAIL | cs_n held low after the last rise
  // GAP   | cs_n high before the next frame may start
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] PH_LAST   = DW'(SCLK_DIV - 1);

  state_t        state, state_nxt;
  logic [DW-1:0] ph_cnt, ph_cnt_nxt;
  logic          hi, hi_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic [15:0]   shreg, shreg_nxt;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [15:0]   conv_sample;
  logic          active_nxt;
  logic          overrun_nxt;

`ifdef DAC_OFFSET_BINARY_EN
  assign conv_sample = {~sample[15], sample[14:0]};
`else
  assign conv_sample = sample;
`endif

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  always_comb begin
    state_nxt   = state;
    ph_cnt_nxt  = ph_cnt;
    hi_nxt      = hi;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    case (state)
      IDLE: begin
        if (tick && activein) begin
          state_nxt  = LEAD;
          ph_cnt_nxt = PH_LAST;
          shreg_nxt  = conv_sample;
        end
      end
      LEAD: begin
        if (ph_cnt == '0) begin
          state_nxt   = SHIFT;
          ph_cnt_nxt  = PH_LAST;
          hi_nxt      = 1'b0;
          bit_cnt_nxt = 4'd15;
        end else begin
          ph_cnt_nxt = ph_cnt - 1'b1;
        end
      end
      SHIFT: begin
        if (ph_cnt == '0) begin
          ph_cnt_nxt = PH_LAST;
          if (!hi) begin
            hi_nxt = 1'b1;
          end else if (bit_cnt == 4'd0) begin
            state_nxt = TRAIL;
            hi_nxt    = 1'b0;
          end else begin
            // next bit is presented at the start of its low phase
            hi_nxt      = 1'b0;
            bit_cnt_nxt = bit_cnt - 1'b1;
            shreg_nxt   = {shreg[14:0], 1'b0};
          end
        end else begin
          ph_cnt_nxt = ph_cnt - 1'b1;
        end
      end
      TRAIL: begin
        if (ph_cnt == '0) begin
          state_nxt  = GAP;
          ph_cnt_nxt = PH_LAST;
        end else begin
          ph_cnt_nxt = ph_cnt - 1'b1;
        end
      end
      GAP: begin
        if (ph_cnt == '0) state_nxt = IDLE;
        else              ph_cnt_nxt = ph_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // pins are registered from the next-state values so they change with the state
  assign active_nxt  = (state_nxt == LEAD) || (state_nxt == SHIFT) || (state_nxt == TRAIL);
  assign overrun_nxt = (tick && (state != IDLE)) ? 1'b1 :
                       clear_overrun             ? 1'b0 : overrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ph_cnt     <= '0;
      hi         <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      cs_n       <= 1'b1;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      ph_cnt     <= ph_cnt_nxt;
      hi         <= hi_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      cs_n       <= !active_nxt;
      sclk       <= (state_nxt == SHIFT) && hi_nxt;
      mosi       <= active_nxt ? shreg_nxt[15] : 1'b0;
      busy       <= (state_nxt != IDLE);
      frame_done <= (state_nxt == GAP) && (ph_cnt_nxt == '0);
      overrun    <= overrun_nxt;
    end
  end

endmodule
